// File: rtl/data_generate.sv
// im2col stream generator: buffers a band of input rows in a circular line buffer
// and replays every Kernel_Size x Kernel_Size patch once per output-channel group.
module data_generate #(
  parameter int DATA_W   = 64,
  parameter int MAX_WIN  = 16,
  parameter int MAX_COLS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sData_valid,
  output logic              sData_ready,
  input  logic [DATA_W-1:0] sData_payload,
  input  logic [7:0]        Stride,
  input  logic [7:0]        Kernel_Size,
  input  logic [7:0]        Window_Size,
  input  logic [15:0]       InFeature_Size,
  input  logic [15:0]       InFeature_Channel,
  input  logic [15:0]       OutFeature_Channel,
  input  logic [15:0]       OutFeature_Channel_Count_Times,
  input  logic [15:0]       OutFeature_Size,
  input  logic [15:0]       OutCol_Count_Times,
  input  logic [15:0]       OutRow_Count_Times,
  input  logic [15:0]       InCol_Count_Times,
  output logic [DATA_W-1:0] mData,
  output logic              mValid,
  output logic              Test_Signal,
  input  logic [15:0]       Test_Generate_Period
);

  localparam int RW = $clog2(MAX_WIN);
  localparam int CW = $clog2(MAX_COLS);
  localparam int AW = RW + CW;
  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, GEN = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [0:(2**AW)-1];

  logic [15:0] col;
  logic [7:0]  row_ptr;
  logic [7:0]  rows_filled;
  logic [7:0]  band_base;
  logic [15:0] band_cnt;
  logic [15:0] g, c, p;
  logic [7:0]  kr, kc;
  logic [15:0] patch_col;
  logic [15:0] group_col;
  logic [15:0] ppg;

  logic          accept;
  logic [7:0]    rows_needed;
  logic          col_last, row_ptr_last, fill_last_row;
  logic          kc_last, kr_last, p_last, c_last, g_last;
  logic [8:0]    row_sum;
  logic [8:0]    base_sum;
  logic [RW-1:0] rd_row;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [15:0]   band_next;
  logic          unused_cfg;

  function automatic logic [DATA_W-1:0] chan_mask(input logic [15:0] n);
    logic [DATA_W-1:0] m;
    m = {DATA_W{1'b0}};
    for (int i = 0; i < NB; i++) begin
      m[i*8 +: 8] = (16'(i) < n) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

  assign unused_cfg    = ^{InFeature_Size, OutFeature_Channel};
  assign accept        = sData_valid && sData_ready && (state == FILL);
  assign rows_needed   = (band_cnt == 16'd0) ? Kernel_Size : Stride;
  assign col_last      = (col == InCol_Count_Times - 16'd1);
  assign row_ptr_last  = (row_ptr == Window_Size - 8'd1);
  assign fill_last_row = (rows_filled == rows_needed - 8'd1);
  assign wr_addr       = {RW'(row_ptr), CW'(col)};

  assign kc_last = (kc == Kernel_Size - 8'd1);
  assign kr_last = (kr == Kernel_Size - 8'd1);
  assign p_last  = (p == ppg - 16'd1);
  assign c_last  = (c == OutFeature_Channel_Count_Times - 16'd1);
  assign g_last  = (g == OutCol_Count_Times - 16'd1);

  // band_base and kr are both below Window_Size, so one conditional subtract wraps the row
  assign row_sum   = {1'b0, band_base} + {1'b0, kr};
  assign rd_row    = RW'((row_sum >= {1'b0, Window_Size}) ? row_sum - {1'b0, Window_Size} : row_sum);
  assign rd_addr   = {rd_row, CW'(patch_col + {8'h00, kc})};
  assign base_sum  = {1'b0, band_base} + {1'b0, Stride};
  assign band_next = band_cnt + 16'd1;

  // Line buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr] <= sData_payload;
    end
  end

  // Sequencer, fill/generate counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sData_ready <= 1'b0;
      mValid      <= 1'b0;
      mData       <= {DATA_W{1'b0}};
      Test_Signal <= 1'b0;
      col         <= 16'd0;
      row_ptr     <= 8'd0;
      rows_filled <= 8'd0;
      band_base   <= 8'd0;
      band_cnt    <= 16'd0;
      g           <= 16'd0;
      c           <= 16'd0;
      p           <= 16'd0;
      kr          <= 8'd0;
      kc          <= 8'd0;
      patch_col   <= 16'd0;
      group_col   <= 16'd0;
      ppg         <= 16'd0;
    end else begin
      mValid      <= (state == GEN);
      Test_Signal <= (state == GEN) && (c < Test_Generate_Period);
      mData       <= (state == GEN) ? (mem[rd_addr] & chan_mask(InFeature_Channel))
                                    : {DATA_W{1'b0}};
      case (state)
        IDLE: begin
          sData_ready <= 1'b0;
          if (start) begin
            state       <= FILL;
            sData_ready <= 1'b1;
            col         <= 16'd0;
            row_ptr     <= 8'd0;
            rows_filled <= 8'd0;
            band_base   <= 8'd0;
            band_cnt    <= 16'd0;
            g           <= 16'd0;
            c           <= 16'd0;
            p           <= 16'd0;
            kr          <= 8'd0;
            kc          <= 8'd0;
            patch_col   <= 16'd0;
            group_col   <= 16'd0;
            ppg         <= (OutCol_Count_Times == 16'd0) ? OutFeature_Size
                                                         : OutFeature_Size / OutCol_Count_Times;
          end
        end
        FILL: begin
          if (accept) begin
            if (col_last) begin
              col         <= 16'd0;
              row_ptr     <= row_ptr_last ? 8'd0 : row_ptr + 8'd1;
              rows_filled <= rows_filled + 8'd1;
              if (fill_last_row) begin
                rows_filled <= 8'd0;
                state       <= GEN;
                sData_ready <= 1'b0;
              end
            end else begin
              col <= col + 16'd1;
            end
          end
        end
        GEN: begin
          if (!kc_last) begin
            kc <= kc + 8'd1;
          end else begin
            kc <= 8'd0;
            if (!kr_last) begin
              kr <= kr + 8'd1;
            end else begin
              kr <= 8'd0;
              if (!p_last) begin
                p         <= p + 16'd1;
                patch_col <= patch_col + {8'h00, Stride};
              end else begin
                p <= 16'd0;
                if (!c_last) begin
                  // replay the same patch group for the next channel repeat
                  c         <= c + 16'd1;
                  patch_col <= group_col;
                end else begin
                  c <= 16'd0;
                  if (!g_last) begin
                    g         <= g + 16'd1;
                    patch_col <= patch_col + {8'h00, Stride};
                    group_col <= patch_col + {8'h00, Stride};
                  end else begin
                    g         <= 16'd0;
                    patch_col <= 16'd0;
                    group_col <= 16'd0;
                    band_cnt  <= band_next;
                    band_base <= 8'(base_sum % {1'b0, Window_Size});
                    if (band_next < OutRow_Count_Times) begin
                      state       <= FILL;
                      sData_ready <= 1'b1;
                    end else begin
                      state       <= IDLE;
                      sData_ready <= 1'b0;
                    end
                  end
                end
              end
            end
          end
        end
        default: begin
          state       <= IDLE;
          sData_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_generate.sv
// Bench for data_generate: directed and randomized frames checked against an
// im2col model that indexes the whole input image directly.
module tb_data_generate;

  logic        clk = 1'b0;
  logic        reset, start, sData_valid, sData_ready;
  logic [63:0] sData_payload, mData;
  logic [7:0]  Stride, Kernel_Size, Window_Size;
  logic [15:0] InFeature_Size, InFeature_Channel, OutFeature_Channel;
  logic [15:0] OutFeature_Channel_Count_Times, OutFeature_Size, OutCol_Count_Times;
  logic [15:0] OutRow_Count_Times, InCol_Count_Times, Test_Generate_Period;
  logic        mValid, Test_Signal;

  always #5 clk = ~clk;

  data_generate dut (
    .clk(clk), .reset(reset), .start(start),
    .sData_valid(sData_valid), .sData_ready(sData_ready), .sData_payload(sData_payload),
    .Stride(Stride), .Kernel_Size(Kernel_Size), .Window_Size(Window_Size),
    .InFeature_Size(InFeature_Size), .InFeature_Channel(InFeature_Channel),
    .OutFeature_Channel(OutFeature_Channel),
    .OutFeature_Channel_Count_Times(OutFeature_Channel_Count_Times),
    .OutFeature_Size(OutFeature_Size), .OutCol_Count_Times(OutCol_Count_Times),
    .OutRow_Count_Times(OutRow_Count_Times), .InCol_Count_Times(InCol_Count_Times),
    .mData(mData), .mValid(mValid), .Test_Signal(Test_Signal),
    .Test_Generate_Period(Test_Generate_Period)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] obs_d[$], exp_d[$];
  logic        obs_t[$], exp_t[$];
  int          obs_c[$];

  always @(negedge clk) begin
    if (mValid) begin
      obs_d.push_back(mData);
      obs_t.push_back(Test_Signal);
      obs_c.push_back(cyc);
    end
  end

  int ncomp = 0, nfail = 0;
  bit stalled = 1'b0;

  int K, S, W, OFS, OC, CNT, NOR, CH, TGP, rows_in, cols_in;
  logic [63:0] img [0:31][0:63];
  int fill_end [0:15];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    ncomp++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic apply_cfg();
    rows_in = K + (NOR - 1) * S;
    Kernel_Size = 8'(K); Stride = 8'(S); Window_Size = 8'(W);
    InFeature_Size = 16'(cols_in); InCol_Count_Times = 16'(cols_in);
    InFeature_Channel = 16'(CH); OutFeature_Channel = 16'(CNT * 8);
    OutFeature_Channel_Count_Times = 16'(CNT); OutFeature_Size = 16'(OFS);
    OutCol_Count_Times = 16'(OC); OutRow_Count_Times = 16'(NOR);
    Test_Generate_Period = 16'(TGP);
  endtask

  task automatic fill_img(input bit rnd);
    for (int r = 0; r < rows_in; r++)
      for (int x = 0; x < cols_in; x++)
        img[r][x] = rnd ? {$urandom, $urandom} : 64'(r * cols_in + x);
  endtask

  // Reference: band b covers input rows b*S .. b*S+K-1 of the full image.
  task automatic build_expected();
    int ppg;
    logic [63:0] v;
    ppg = OFS / OC;
    exp_d.delete(); exp_t.delete();
    for (int b = 0; b < NOR; b++)
      for (int g = 0; g < OC; g++)
        for (int c = 0; c < CNT; c++)
          for (int p = 0; p < ppg; p++)
            for (int kr = 0; kr < K; kr++)
              for (int kc = 0; kc < K; kc++) begin
                v = img[b * S + kr][(g * ppg + p) * S + kc];
                for (int i = 0; i < 8; i++) if (i >= CH) v[i*8 +: 8] = 8'h00;
                exp_d.push_back(v);
                exp_t.push_back(c < TGP);
              end
  endtask

  task automatic drive_beat(input logic [63:0] d, input bit drop, output int acc);
    int w;
    w = 0;
    acc = -1;
    if (!stalled) begin
      while (drop && $urandom_range(0, 3) == 0) begin
        sData_valid = 1'b0;
        @(negedge clk);
      end
      sData_valid = 1'b1;
      sData_payload = d;
      while (!sData_ready && w < 3000) begin
        @(negedge clk);
        w++;
      end
      if (!sData_ready) begin
        stalled = 1'b1;
        check("ready_timeout", 64'(sData_ready), 64'd1);
      end else begin
        @(negedge clk);
        acc = cyc;
      end
      sData_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input bit drop, input bit hold_start);
    int acc, idx, w, n, wpb;
    build_expected();
    obs_d.delete(); obs_t.delete(); obs_c.delete();
    stalled = 1'b0;
    if (!sData_ready) begin
      start = 1'b1;
      @(negedge clk);
    end
    start = hold_start;
    idx = 0;
    for (int r = 0; r < rows_in; r++)
      for (int x = 0; x < cols_in; x++) begin
        drive_beat(img[r][x], drop, acc);
        for (int b = 0; b < NOR; b++)
          if (idx == (K + b * S) * cols_in - 1) fill_end[b] = acc;
        idx++;
      end
    w = 0;
    while (obs_d.size() < exp_d.size() && w < 5000) begin
      @(negedge clk);
      w++;
    end
    repeat (8) @(negedge clk);
    check("word_count", 64'(obs_d.size()), 64'(exp_d.size()));
    n = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
    wpb = OFS * CNT * K * K;
    for (int i = 0; i < n; i++) begin
      check("mData", obs_d[i], exp_d[i]);
      check("Test_Signal", 64'(obs_t[i]), 64'(exp_t[i]));
      check("word_cycle", 64'(obs_c[i]), 64'(fill_end[i / wpb] + 1 + (i % wpb)));
    end
    check("ready_after_frame", 64'(sData_ready), 64'(hold_start));
  endtask

  task automatic random_cfg();
    int ppg;
    K = $urandom_range(1, 3);
    S = $urandom_range(1, K);
    W = $urandom_range(K, K + 2);
    ppg = $urandom_range(1, 3);
    OC = $urandom_range(1, 2);
    OFS = ppg * OC;
    CNT = $urandom_range(1, 2);
    NOR = $urandom_range(1, 3);
    CH = $urandom_range(1, 8);
    TGP = $urandom_range(0, 2);
    cols_in = (OFS - 1) * S + K + $urandom_range(0, 1);
    apply_cfg();
  endtask

  int small_seq [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int ovl_seq [8] = '{3, 4, 6, 7, 4, 5, 7, 8};

  initial begin
    int w;
    reset = 1'b0; start = 1'b0; sData_valid = 1'b1; sData_payload = 64'd0;
    K = 2; S = 2; W = 2; OFS = 2; OC = 1; CNT = 1; NOR = 2; CH = 8; TGP = 1; cols_in = 4;
    apply_cfg();
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(sData_ready), 64'd0);
    check("reset_mValid", 64'(mValid), 64'd0);
    check("reset_mData", mData, 64'd0);
    check("reset_Test_Signal", 64'(Test_Signal), 64'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_ready", 64'(sData_ready), 64'd0);
    check("idle_mValid", 64'(mValid), 64'd0);
    sData_valid = 1'b0;

    // Small frame with pixel value row*4+col.
    fill_img(1'b0);
    run_frame(1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      if (i < obs_d.size()) check("small_seq", obs_d[i], 64'(small_seq[i]));

    // Repeats and grouping.
    CNT = 2; OC = 2; TGP = 1;
    apply_cfg();
    fill_img(1'b0);
    run_frame(1'b1, 1'b0);

    // Channel mask.
    CNT = 1; OC = 1; CH = 3;
    apply_cfg();
    for (int r = 0; r < rows_in; r++)
      for (int x = 0; x < cols_in; x++) img[r][x] = 64'h0807060504030201;
    run_frame(1'b0, 1'b0);
    if (obs_d.size() > 0) check("chan_mask", obs_d[0], 64'h0000000000030201);

    // Abort with reset during generation.
    CH = 8;
    apply_cfg();
    fill_img(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int x = 0; x < 8; x++) begin
      int acc;
      drive_beat(img[x / 4][x % 4], 1'b0, acc);
    end
    w = 0;
    while (!mValid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("abort_gen_running", 64'(mValid), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_mValid", 64'(mValid), 64'd0);
    check("abort_ready", 64'(sData_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_idle_ready", 64'(sData_ready), 64'd0);
    check("abort_idle_mValid", 64'(mValid), 64'd0);

    // Overlapping stride.
    K = 2; S = 1; W = 3; OFS = 2; OC = 1; CNT = 1; NOR = 2; CH = 8; TGP = 1; cols_in = 3;
    apply_cfg();
    fill_img(1'b0);
    run_frame(1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      if (i + 8 < obs_d.size()) check("overlap_band1", obs_d[i + 8], 64'(ovl_seq[i]));

    // start held high: the second frame begins straight after the first.
    random_cfg();
    fill_img(1'b1);
    run_frame(1'b1, 1'b1);
    fill_img(1'b1);
    run_frame(1'b1, 1'b0);

    for (int t = 0; t < 3; t++) begin
      random_cfg();
      fill_img(1'b1);
      run_frame(1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/data_generate.md
Name: data_generate

Overview:
- Image-to-column (im2col) streaming generator for the patch-embedding front end.
- Accepts an input feature map one pixel per 64-bit beat, raster order. Each beat carries up to 8 channel bytes, channel 0 in bits [7:0].
- Buffers one band of input rows and re-emits each Kernel_Size x Kernel_Size patch as a word stream. The stream is repeated once per 8-output-channel group for the downstream systolic array.

Parameters:
- DATA_W, 64: beat width (8 bytes).
- MAX_WIN, 16: maximum rows held in the line buffer (upper bound for Window_Size).
- MAX_COLS, 256: maximum pixels per row; line buffer depth is MAX_WIN*MAX_COLS words.

Ports:
- clk, in, 1: clock, all logic on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: level; begins a frame when sampled high in IDLE.
- sData_valid, in, 1: input beat valid.
- sData_ready, out, 1: input beat accepted when valid && ready.
- sData_payload, in, 64: one pixel, channel bytes.
- Stride, in, 8: patch step in rows and columns.
- Kernel_Size, in, 8: patch height and width.
- Window_Size, in, 8: circular row-buffer depth in rows; must be >= Kernel_Size and <= MAX_WIN.
- InFeature_Size, in, 16: input width/height in pixels.
- InFeature_Channel, in, 16: valid channel bytes per beat (1..8).
- OutFeature_Channel, in, 16: informational only; not used by the datapath.
- OutFeature_Channel_Count_Times, in, 16: repeats per patch group (OutFeature_Channel/8).
- OutFeature_Size, in, 16: patches per band.
- OutCol_Count_Times, in, 16: patch groups per band; must divide OutFeature_Size.
- OutRow_Count_Times, in, 16: bands per frame.
- InCol_Count_Times, in, 16: input beats per row.
- mData, out, 64: output word.
- mValid, out, 1: output valid. There is no output backpressure.
- Test_Signal, out, 1: debug dump enable.
- Test_Generate_Period, in, 16: number of leading repeats flagged by Test_Signal.

Behaviour:
- Reset values: sData_ready=0, mValid=0, mData=0, Test_Signal=0, all counters 0, state IDLE.

Input write side (state FILL):
- sData_ready=1 in FILL only.
- Each accepted beat is written to buffer address (row_ptr*MAX_COLS + col).
- col wraps at InCol_Count_Times-1. Each wrap increments row_ptr, which wraps at Window_Size-1.
- FILL ends when the required row count has been accepted: Kernel_Size rows for band 0, Stride rows for every later band.
- Transition FILL->GEN on the cycle that accepts the final beat. sData_ready drops on the next cycle.

Output side (state GEN, one word per cycle, unconditionally):
- Loop order, outer to inner:
  - g in [0, OutCol_Count_Times)
  - c in [0, OutFeature_Channel_Count_Times)
  - p in [0, OutFeature_Size/OutCol_Count_Times)
  - kr in [0, Kernel_Size)
  - kc in [0, Kernel_Size)
- Patch index = g*(OutFeature_Size/OutCol_Count_Times) + p.
- Source pixel: row = (band_base + kr) mod Window_Size, col = patch*Stride + kc.
- band_base starts at 0 and advances by Stride (mod Window_Size) after each band.

Latency and formatting:
- Buffer read is registered: mData/mValid appear 1 cycle after the address is issued.
- mValid is high for exactly the band's word count per band: OutFeature_Size*OutFeature_Channel_Count_Times*Kernel_Size^2.
- Output bytes with index >= InFeature_Channel are forced to 0.
- Test_Signal = mValid && (c of that word < Test_Generate_Period), aligned with mData.

Band and frame sequencing:
- After the last word of a band, if bands done < OutRow_Count_Times, go to FILL. Otherwise go to IDLE.
- IDLE with start=1 starts a new frame on the next cycle: counters cleared, band 0, FILL.
- start is ignored outside IDLE.
- Input beats presented in IDLE or GEN are not accepted (ready low) and are not lost.
- Reset mid-operation aborts immediately to IDLE and clears all counters. Buffer contents are don't-care.
- Generation never overlaps filling, so Window_Size >= Kernel_Size guarantees no row is overwritten while still needed.

Test Plan:
- Reset/idle: reset low, start=0, sData_valid=1 -> sData_ready=0, mValid=0, no state change.
- Small frame:
  - Config: InFeature_Size=InCol_Count_Times=4, Kernel=Stride=Window=2, OutFeature_Size=2, OutCol=1, Count_Times=1, OutRow=2, Channel=8.
  - Stimulus: pixel value = row*4+col.
  - Response: band 0 emits 0,1,4,5,2,3,6,7 (one word per cycle, 1 cycle after FILL ends); band 1 emits 8,9,12,13,10,11,14,15; then IDLE.
- Repeat and grouping:
  - Same frame with Count_Times=2, OutCol=2.
  - Response: band 0 emits 0,1,4,5 twice, then 2,3,6,7 twice.
  - Test_Signal with Test_Generate_Period=1 is high only on the first copy of each.
- Channel mask: InFeature_Channel=3, payload 64'h0807060504030201 -> mData=64'h0000000000030201.
- Overlapping stride:
  - Config: Kernel=2, Stride=1, Window=3, 3x3 input, OutFeature_Size=2, OutRow=2.
  - Response: band 1 reuses row 1, fills only row 2 (3 beats), then emits 3,4,6,7,4,5,7,8.
- Backpressure and restart: drop sData_valid randomly during FILL -> output unchanged; start held high -> second frame begins the cycle after IDLE; reset mid-GEN -> mValid=0 immediately.
